// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared types, defaults and width helper for the sequential multiplier
package mult_seq_pkg;

  localparam int CORE_W_DEF     = 4;
  localparam int NUM_DIGITS_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a digit index; never below one bit so the counters stay real signals.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_core.sv
// rtl/mult_core.sv - CORE_W x CORE_W unsigned combinational multiplier core
module mult_core #(
  parameter int CORE_W = 4
) (
  input  logic [CORE_W-1:0]   a,
  input  logic [CORE_W-1:0]   b,
  output logic [2*CORE_W-1:0] p
);

  // Full-width product; both operands widened so no bits are lost.
  always_comb begin
    p = {{CORE_W{1'b0}}, a} * {{CORE_W{1'b0}}, b};
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - digit-serial W x W multiplier sequencing one shared core
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int CORE_W     = CORE_W_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CORE_W*NUM_DIGITS-1:0]   in_a,
  input  logic [CORE_W*NUM_DIGITS-1:0]   in_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2*CORE_W*NUM_DIGITS-1:0] out_p,
  output logic                           busy
);

  localparam int W   = CORE_W * NUM_DIGITS;
  localparam int PW  = 2 * W;
  localparam int IW  = idx_w(NUM_DIGITS);
  localparam int SHW = $clog2(PW);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  state_t state, state_next;

  logic [W-1:0]        a_reg, b_reg;
  logic [PW-1:0]       acc;
  logic [IW-1:0]       i, j;
  logic [CORE_W-1:0]   core_a, core_b;
  logic [2*CORE_W-1:0] core_p;
  logic [SHW-1:0]      shamt;
  logic [PW-1:0]       term;
  logic                accept;
  logic                last_pair;

  // Digit muxes feed the single shared core; the partial product lands at weight i+j.
  assign core_a    = a_reg[i*CORE_W +: CORE_W];
  assign core_b    = b_reg[j*CORE_W +: CORE_W];
  assign shamt     = SHW'(CORE_W) * (SHW'(i) + SHW'(j));
  assign term      = {{(PW-2*CORE_W){1'b0}}, core_p} << shamt;
  assign last_pair = (i == LAST) && (j == LAST);

  mult_core #(.CORE_W(CORE_W)) u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake decode; in_ready is held low while reset is asserted.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        accept   = in_valid & ~rst;
        if (accept) state_next = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (last_pair) state_next = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, digit counters, shift-accumulator and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
          end
        end
        MUL: begin
          acc <= acc + term;
          if (last_pair) begin
            i         <= '0;
            j         <= '0;
            out_p     <= acc + term;
            out_valid <= 1'b1;
          end else if (j == LAST) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          // out_p deliberately keeps the last product after the handshake.
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
